// File: rtl/not_game_pkg.sv
// Shared types and helpers for the NOT-NOT round controller: FSM states,
// scene codes, LFSR taps and the opposite-button mapping.
package not_game_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRAW_START,
      S_HOLD_START,
      S_CLR_START,
      S_NEW_INS,
      S_DRAW_INS,
      S_WAIT_PRESS,
      S_WAIT_RELEASE,
      S_CLR_INS,
      S_DRAW_FB,
      S_SHOW_FB,
      S_CLR_FB,
      S_DRAW_OVER,
      S_OVER
   } state_e;

   localparam logic [2:0] SC_CLEAR   = 3'd0;
   localparam logic [2:0] SC_START   = 3'd1;
   localparam logic [2:0] SC_INS     = 3'd2;
   localparam logic [2:0] SC_CORRECT = 3'd3;
   localparam logic [2:0] SC_WRONG   = 3'd4;
   localparam logic [2:0] SC_OVER    = 3'd5;

   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [2:0] opposite_idx(input logic [2:0] idx);
      return idx ^ 3'd1;
   endfunction

   function automatic logic is_draw(input state_e s);
      case (s)
         S_DRAW_START, S_CLR_START, S_DRAW_INS, S_CLR_INS,
         S_DRAW_FB, S_CLR_FB, S_DRAW_OVER: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] scene_of(input state_e s, input logic correct);
      case (s)
         S_DRAW_START: return SC_START;
         S_DRAW_INS:   return SC_INS;
         S_DRAW_FB:    return correct ? SC_CORRECT : SC_WRONG;
         S_DRAW_OVER:  return SC_OVER;
         default:      return SC_CLEAR;
      endcase
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/not_game_timer.sv
// Shared down-counter: load N-1 on entry to a timed state, expired while the
// count sits at zero, giving exactly N cycles in that state.
module not_game_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/not_game_round_ctrl.sv
// NOT-NOT round controller: start screen, instruction, timed response, judgement,
// feedback and game over. Optional NOT_GAME_SPEEDUP_EN shrinks the response window.
module not_game_round_ctrl
   import not_game_pkg::*;
#(
   parameter int         N_IN      = 6,
   parameter int         START_CYC = 150000000,
   parameter int         RESP_CYC  = 100000000,
   parameter int         FEED_CYC  = 50000000,
   parameter int         SCORE_W   = 8,
   parameter int         LIVES     = 3,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [N_IN-1:0]    user_input,
   input  logic               draw_done,
   output logic               draw_req,
   output logic [2:0]         draw_scene,
   output logic [2:0]         ins_code,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         lives,
   output logic               game_over
);

   localparam int MAX_CYC = max3(START_CYC, RESP_CYC, FEED_CYC);
   localparam int TW      = $clog2(MAX_CYC + 1);

   state_e             state_q, state_d;
   logic               draw_req_q, draw_req_d;
   logic [2:0]         scene_q, scene_d;
   logic [2:0]         ins_q, ins_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         lives_q, lives_d;
   logic               correct_q, correct_d;
   logic [7:0]         lfsr_q, lfsr_d;

   logic               accept;
   logic               tmr_load;
   logic [TW-1:0]      tmr_val;
   logic               tmr_expired;
   logic [TW-1:0]      win_cur;
   logic [N_IN-1:0]    exp_onehot;
   logic               press_ok;
   logic [2:0]         lives_dec;

`ifdef NOT_GAME_SPEEDUP_EN
   localparam logic [TW-1:0] WIN_STEP = TW'(RESP_CYC >> 4);
   localparam logic [TW-1:0] WIN_MIN  = TW'(RESP_CYC >> 2);
   logic [TW-1:0] win_q, win_d;
   assign win_cur = win_q;
`else
   assign win_cur = TW'(RESP_CYC);
`endif

   not_game_timer #(.W(TW)) u_timer (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   // A done pulse only counts while a request is outstanding.
   assign accept     = draw_req_q & draw_done;
   assign exp_onehot = N_IN'(1) << opposite_idx(ins_q);
   assign press_ok   = (user_input == exp_onehot);
   assign lives_dec  = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
   assign lfsr_d     = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);

   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      correct_d = correct_q;
      ins_d     = ins_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
`ifdef NOT_GAME_SPEEDUP_EN
      win_d     = win_q;
`endif
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d = S_DRAW_START;
               score_d = '0;
               lives_d = 3'(LIVES);
`ifdef NOT_GAME_SPEEDUP_EN
               win_d   = TW'(RESP_CYC);
`endif
            end
         end
         S_DRAW_START: begin
            if (accept) begin
               state_d  = S_HOLD_START;
               tmr_load = 1'b1;
               tmr_val  = TW'(START_CYC - 1);
            end
         end
         S_HOLD_START: if (tmr_expired) state_d = S_CLR_START;
         S_CLR_START:  if (accept) state_d = S_NEW_INS;
         S_NEW_INS: begin
            ins_d   = 3'(lfsr_q % 8'(N_IN));
            state_d = S_DRAW_INS;
         end
         S_DRAW_INS: begin
            if (accept) begin
               state_d  = S_WAIT_PRESS;
               tmr_load = 1'b1;
               tmr_val  = win_cur - TW'(1);
            end
         end
         // A press in the expiry cycle still counts as a press.
         S_WAIT_PRESS: begin
            if (user_input != '0) begin
               state_d   = S_WAIT_RELEASE;
               correct_d = press_ok;
               if (press_ok) begin
                  if (score_q != '1) score_d = score_q + SCORE_W'(1);
`ifdef NOT_GAME_SPEEDUP_EN
                  win_d = (win_q >= WIN_MIN + WIN_STEP) ? win_q - WIN_STEP : WIN_MIN;
`endif
               end else begin
                  lives_d = lives_dec;
               end
            end else if (tmr_expired) begin
               state_d   = S_CLR_INS;
               correct_d = 1'b0;
               lives_d   = lives_dec;
            end
         end
         S_WAIT_RELEASE: if (user_input == '0) state_d = S_CLR_INS;
         S_CLR_INS:      if (accept) state_d = S_DRAW_FB;
         S_DRAW_FB: begin
            if (accept) begin
               state_d  = S_SHOW_FB;
               tmr_load = 1'b1;
               tmr_val  = TW'(FEED_CYC - 1);
            end
         end
         S_SHOW_FB: if (tmr_expired) state_d = S_CLR_FB;
         S_CLR_FB: begin
            if (accept) state_d = (lives_q == 3'd0) ? S_DRAW_OVER : S_NEW_INS;
         end
         S_DRAW_OVER: if (accept) state_d = S_OVER;
         default:     state_d = S_IDLE;
      endcase

      // Every accepted done drops the request for at least one cycle.
      draw_req_d = is_draw(state_d) & ~accept;
      scene_d    = is_draw(state_d) ? scene_of(state_d, correct_d) : scene_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         draw_req_q <= 1'b0;
         scene_q    <= SC_CLEAR;
         ins_q      <= 3'd0;
         score_q    <= '0;
         lives_q    <= 3'(LIVES);
         correct_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
      end else begin
         state_q    <= state_d;
         draw_req_q <= draw_req_d;
         scene_q    <= scene_d;
         ins_q      <= ins_d;
         score_q    <= score_d;
         lives_q    <= lives_d;
         correct_q  <= correct_d;
         lfsr_q     <= lfsr_d;
      end
   end

`ifdef NOT_GAME_SPEEDUP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_q <= TW'(RESP_CYC);
      end else begin
         win_q <= win_d;
      end
   end
`endif

   assign draw_req   = draw_req_q;
   assign draw_scene = scene_q;
   assign ins_code   = ins_q;
   assign score      = score_q;
   assign lives      = lives_q;
   assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_not_game_round_ctrl.sv
// Scenario bench for not_game_round_ctrl with a 2-cycle drawer model and a
// feedback scoreboard; the NOT_GAME_SPEEDUP_EN build uses a 64-cycle window.
module tb_not_game_round_ctrl;

   localparam int N_IN      = 6;
   localparam int START_CYC = 4;
   localparam int FEED_CYC  = 3;
   localparam int SCORE_W   = 8;
   localparam int LIVES     = 2;
`ifdef NOT_GAME_SPEEDUP_EN
   localparam int RESP_CYC  = 64;
`else
   localparam int RESP_CYC  = 8;
`endif

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic [N_IN-1:0]    user_input;
   logic               draw_done;
   logic               draw_req;
   logic [2:0]         draw_scene;
   logic [2:0]         ins_code;
   logic [SCORE_W-1:0] score;
   logic [2:0]         lives;
   logic               game_over;

   typedef struct packed {
      logic [2:0]         scene;
      logic [SCORE_W-1:0] score;
      logic [2:0]         lives;
   } fb_t;

   fb_t        sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_score, exp_lives, exp_win;
   int         drw_cnt;
   logic [7:0] lfsr_m, lfsr_prev;

   always #5 clk = ~clk;

   not_game_round_ctrl #(
      .N_IN(N_IN), .START_CYC(START_CYC), .RESP_CYC(RESP_CYC), .FEED_CYC(FEED_CYC),
      .SCORE_W(SCORE_W), .LIVES(LIVES), .LFSR_SEED(8'hA5)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .user_input(user_input),
      .draw_done(draw_done), .draw_req(draw_req), .draw_scene(draw_scene),
      .ins_code(ins_code), .score(score), .lives(lives), .game_over(game_over)
   );

   // Drawer: one-cycle done pulse two cycles after it first sees a request.
   always @(posedge clk) begin
      if (!reset_n || !draw_req) begin
         drw_cnt   <= 0;
         draw_done <= 1'b0;
      end else begin
         drw_cnt   <= drw_cnt + 1;
         draw_done <= (drw_cnt == 1);
      end
   end

   // Reference LFSR, x^8+x^6+x^5+x^4+1, written out bit by bit.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_m    <= 8'hA5;
         lfsr_prev <= 8'hA5;
      end else begin
         lfsr_prev <= lfsr_m;
         lfsr_m    <= {lfsr_m[0], lfsr_m[7], lfsr_m[6] ^ lfsr_m[0], lfsr_m[5] ^ lfsr_m[0],
                       lfsr_m[4] ^ lfsr_m[0], lfsr_m[3], lfsr_m[2], lfsr_m[1]};
      end
   end

   function automatic int next_win(input int w);
`ifdef NOT_GAME_SPEEDUP_EN
      return (w - RESP_CYC / 16 < RESP_CYC / 4) ? RESP_CYC / 4 : w - RESP_CYC / 16;
`else
      return w;
`endif
   endfunction

   task automatic step_req(input logic lvl, output int n);
      n = 0;
      while (draw_req !== lvl && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (draw_req !== lvl) begin
         errors++;
         $display("FAIL wait_draw_req: draw_req=%b after %0d cycles, required %b", draw_req, n, lvl);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({draw_req, draw_scene, ins_code, score, lives, game_over} !==
          {1'b0, 3'd0, 3'd0, 8'd0, 3'(LIVES), 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: req=%b scene=%0d ins=%0d score=%0d lives=%0d over=%b, required 0/0/0/0/%0d/0",
                  draw_req, draw_scene, ins_code, score, lives, game_over, LIVES);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (draw_req !== 1'b0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet: req=%b over=%b, required 0/0", draw_req, game_over);
      end
   endtask

   task automatic test_new_ins();
      int n;
      step_req(1'b1, n);
      checks++;
      if (n !== 1 || draw_scene !== 3'd2) begin
         errors++;
         $display("FAIL new_ins_request: gap=%0d scene=%0d, required 1/2", n, draw_scene);
      end
      checks++;
      if (ins_code !== 3'(lfsr_prev % N_IN)) begin
         errors++;
         $display("FAIL ins_code: got %0d, required %0d", ins_code, lfsr_prev % N_IN);
      end
      step_req(1'b0, n);
   endtask

   task automatic test_start();
      int n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_score = 0; exp_lives = LIVES; exp_win = RESP_CYC;
      step_req(1'b1, n);
      checks++;
      if (draw_scene !== 3'd1) begin
         errors++;
         $display("FAIL start_scene: got %0d, required 1", draw_scene);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      checks++;
      if (n !== START_CYC || draw_scene !== 3'd0) begin
         errors++;
         $display("FAIL start_hold: held %0d scene=%0d, required %0d/0", n, draw_scene, START_CYC);
      end
      step_req(1'b0, n);
      test_new_ins();
   endtask

   task automatic test_correct_hold();
      int n;
      fb_t e, g;
      user_input = N_IN'(1) << (ins_code ^ 3'd1);
      exp_score++; exp_win = next_win(exp_win);
      e.scene = 3'd3; e.score = SCORE_W'(exp_score); e.lives = 3'(exp_lives);
      sb_q.push_back(e);
      repeat (5) @(negedge clk);
      checks++;
      if (draw_req !== 1'b0) begin
         errors++;
         $display("FAIL hold_press: draw_req=%b while button held, required 0", draw_req);
      end
      user_input = '0;
      step_req(1'b1, n);
      checks++;
      if (n !== 1 || draw_scene !== 3'd0) begin
         errors++;
         $display("FAIL clr_after_release: gap=%0d scene=%0d, required 1/0", n, draw_scene);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      g = {draw_scene, score, lives};
      e = sb_q.pop_front();
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL fb_correct: scene/score/lives %0d/%0d/%0d, required %0d/%0d/%0d",
                  g.scene, g.score, g.lives, e.scene, e.score, e.lives);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      checks++;
      if (n !== FEED_CYC || draw_scene !== 3'd0) begin
         errors++;
         $display("FAIL feedback_time: %0d cycles scene=%0d, required %0d/0", n, draw_scene, FEED_CYC);
      end
      step_req(1'b0, n);
      test_new_ins();
   endtask

   task automatic test_two_bits();
      int n;
      fb_t e, g;
      user_input = (N_IN'(1) << (ins_code ^ 3'd1)) | (N_IN'(1) << ins_code);
      exp_lives--;
      e.scene = 3'd4; e.score = SCORE_W'(exp_score); e.lives = 3'(exp_lives);
      sb_q.push_back(e);
      @(negedge clk);
      user_input = '0;
      step_req(1'b1, n);
      step_req(1'b0, n);
      step_req(1'b1, n);
      g = {draw_scene, score, lives};
      e = sb_q.pop_front();
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL fb_two_bits: scene/score/lives %0d/%0d/%0d, required %0d/%0d/%0d",
                  g.scene, g.score, g.lives, e.scene, e.score, e.lives);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      step_req(1'b0, n);
      test_new_ins();
   endtask

   task automatic test_timeout();
      int n;
      fb_t e, g;
      exp_lives--;
      e.scene = 3'd4; e.score = SCORE_W'(exp_score); e.lives = 3'(exp_lives);
      sb_q.push_back(e);
      step_req(1'b1, n);
      checks++;
      if (n !== exp_win || draw_scene !== 3'd0) begin
         errors++;
         $display("FAIL timeout_window: %0d cycles scene=%0d, required %0d/0", n, draw_scene, exp_win);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      g = {draw_scene, score, lives};
      e = sb_q.pop_front();
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL fb_timeout: scene/score/lives %0d/%0d/%0d, required %0d/%0d/%0d",
                  g.scene, g.score, g.lives, e.scene, e.score, e.lives);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      step_req(1'b0, n);
      step_req(1'b1, n);
      checks++;
      if (draw_scene !== 3'd5 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL over_scene: scene=%0d over=%b, required 5/0", draw_scene, game_over);
      end
      step_req(1'b0, n);
      repeat (3) @(negedge clk);
      checks++;
      if ({game_over, draw_req, score, lives} !== {1'b1, 1'b0, SCORE_W'(exp_score), 3'd0}) begin
         errors++;
         $display("FAIL over_state: over=%b req=%b score=%0d lives=%0d, required 1/0/%0d/0",
                  game_over, draw_req, score, lives, exp_score);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_score = 0; exp_lives = LIVES; exp_win = RESP_CYC;
      step_req(1'b1, n);
      checks++;
      if ({draw_scene, score, lives, game_over} !== {3'd1, SCORE_W'(0), 3'(LIVES), 1'b0}) begin
         errors++;
         $display("FAIL restart: scene=%0d score=%0d lives=%0d over=%b, required 1/0/%0d/0",
                  draw_scene, score, lives, game_over, LIVES);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      step_req(1'b0, n);
      test_new_ins();
   endtask

   task automatic test_press_at_expiry();
      int n;
      fb_t e, g;
      repeat (exp_win - 1) @(negedge clk);
      checks++;
      if (draw_req !== 1'b0) begin
         errors++;
         $display("FAIL window_open: draw_req=%b in last window cycle, required 0", draw_req);
      end
      user_input = N_IN'(1) << (ins_code ^ 3'd1);
      start = 1'b1;
      exp_score++; exp_win = next_win(exp_win);
      e.scene = 3'd3; e.score = SCORE_W'(exp_score); e.lives = 3'(exp_lives);
      sb_q.push_back(e);
      @(negedge clk);
      user_input = '0;
      step_req(1'b1, n);
      step_req(1'b0, n);
      step_req(1'b1, n);
      g = {draw_scene, score, lives};
      e = sb_q.pop_front();
      checks++;
      if (g !== e) begin
         errors++;
         $display("FAIL fb_press_at_expiry: scene/score/lives %0d/%0d/%0d, required %0d/%0d/%0d",
                  g.scene, g.score, g.lives, e.scene, e.score, e.lives);
      end
      step_req(1'b0, n);
   endtask

   task automatic test_reset_mid_fb();
      int n;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({draw_req, score, lives, game_over, draw_scene} !== {1'b0, SCORE_W'(0), 3'(LIVES), 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL reset_mid_fb: req=%b score=%0d lives=%0d over=%b scene=%0d, required 0/0/%0d/0/0",
                  draw_req, score, lives, game_over, draw_scene, LIVES);
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_score = 0; exp_lives = LIVES; exp_win = RESP_CYC;
      step_req(1'b1, n);
      start = 1'b0;
      checks++;
      if (draw_scene !== 3'd1) begin
         errors++;
         $display("FAIL start_after_reset: scene=%0d, required 1", draw_scene);
      end
      step_req(1'b0, n);
      step_req(1'b1, n);
      step_req(1'b0, n);
      test_new_ins();
   endtask

   task automatic play(input bit correct, output int win);
      int n;
      win = 0;
      if (correct) begin
         user_input = N_IN'(1) << (ins_code ^ 3'd1);
         exp_score++; exp_win = next_win(exp_win);
         @(negedge clk);
         user_input = '0;
         step_req(1'b1, n);
      end else begin
         exp_lives--;
         step_req(1'b1, win);
      end
      for (int k = 0; k < 7; k++) step_req(k[0] ? 1'b1 : 1'b0, n);
   endtask

   task automatic test_speedup();
      int w;
      for (int i = 0; i < 3; i++) play(1'b1, w);
      play(1'b0, w);
      checks++;
      if (w !== exp_win) begin
         errors++;
         $display("FAIL window_after_3: got %0d, required %0d", w, exp_win);
      end
      for (int i = 0; i < 17; i++) play(1'b1, w);
      play(1'b0, w);
      checks++;
      if (w !== exp_win) begin
         errors++;
         $display("FAIL window_after_20: got %0d, required %0d", w, exp_win);
      end
      checks++;
      if ({game_over, score, lives} !== {1'b1, SCORE_W'(exp_score), 3'd0}) begin
         errors++;
         $display("FAIL speedup_end: over=%b score=%0d lives=%0d, required 1/%0d/0",
                  game_over, score, lives, exp_score);
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      user_input = '0;
      test_reset();
      test_start();
      test_correct_hold();
      test_two_bits();
      test_timeout();
      test_back_to_back();
      test_press_at_expiry();
      test_reset_mid_fb();
      test_speedup();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
